// File: rtl/operand_b_stage.sv
// operand_b_stage: EX operand B select with rs2 forwarding,
// load-use stall detection and a registered valid/ready output.
module operand_b_stage #(
  parameter int XLEN   = 32,
  parameter int REGA_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        sel,
  input  logic [REGA_W-1:0] rs2_addr,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [XLEN-1:0]   imm_s,
  input  logic [XLEN-1:0]   imm_u,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              ex_wr,
  input  logic [REGA_W-1:0] ex_rd,
  input  logic [XLEN-1:0]   ex_data,
  input  logic              ex_is_load,
  input  logic              mem_wr,
  input  logic [REGA_W-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   b_out,
  output logic              illegal_sel,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              r_valid;
  logic [XLEN-1:0]   r_b;
  logic              r_ill;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_rs2_nz;
  logic              w_ex_hit;
  logic              w_mem_hit;
  logic              w_hazard;
  logic              w_ov_eff;
  logic              w_xfer;
  logic              w_stall;
  logic [XLEN-1:0]   w_rs2_val;
  logic [XLEN-1:0]   w_sel_val;
  logic              w_sel_ill;

  assign w_rs2_nz  = (rs2_addr != '0);
  assign w_ex_hit  = ex_wr && (ex_rd == rs2_addr) && w_rs2_nz;
  assign w_mem_hit = mem_wr && (mem_rd == rs2_addr) && w_rs2_nz;
  assign w_hazard  = (sel == 3'b000) && w_ex_hit && ex_is_load;

  // out_valid is treated as 0 while reset is asserted
  assign w_ov_eff  = r_valid && rst_n;
  assign in_ready  = (!w_ov_eff || out_ready)
                   && !w_hazard && !flush;
  assign w_xfer    = in_valid && in_ready;
  assign w_stall   = in_valid && w_hazard && !flush;

  // rs2 forwarding: EX non-load beats MEM beats regfile
  always_comb begin
    w_rs2_val = rs2_data;
    if (w_ex_hit && !ex_is_load) begin
      w_rs2_val = ex_data;
    end else if (w_mem_hit) begin
      w_rs2_val = mem_data;
    end
  end

  // source select decode; reserved codes give zero + flag
  always_comb begin
    w_sel_val = '0;
    w_sel_ill = 1'b0;
    unique case (sel)
      3'b000:  w_sel_val = w_rs2_val;
      3'b001:  w_sel_val = imm_i;
      3'b010:  w_sel_val = imm_s;
      3'b011:  w_sel_val = imm_u;
      3'b100:  w_sel_val = '0;
      default: w_sel_ill = 1'b1;
    endcase
  end

  // output register: flush beats transfer beats drain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_b     <= '0;
      r_ill   <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_b     <= w_sel_val;
      r_ill   <= w_sel_ill;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // saturating count of load-use stall cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_stall && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out_valid   = r_valid;
  assign b_out       = r_b;
  assign illegal_sel = r_ill;
  assign stall_cnt   = r_cnt;

endmodule

// File: tb/tb_operand_b_stage.sv
// tb_operand_b_stage: table vectors, directed corner
// sequences and random stimulus against a reference model.
module tb_operand_b_stage;

  logic        clk;
  logic        rst_n;
  logic [2:0]  sel;
  logic [4:0]  rs2_addr;
  logic [31:0] rs2_data;
  logic [31:0] imm_i, imm_s, imm_u;
  logic        in_valid;
  logic        in_ready, in_ready2;
  logic        ex_wr;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        ex_is_load;
  logic        mem_wr;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        flush;
  logic        out_valid, out_valid2;
  logic        out_ready;
  logic [31:0] b_out, b_out2;
  logic        illegal_sel, illegal_sel2;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;

  int n_vec = 0;
  int n_err = 0;

  bit          m_v;
  logic [31:0] m_b;
  bit          m_ill;
  int unsigned m_cnt;
  int unsigned m_cnt2;

  operand_b_stage dut (
    .clk(clk), .rst_n(rst_n), .sel(sel),
    .rs2_addr(rs2_addr), .rs2_data(rs2_data),
    .imm_i(imm_i), .imm_s(imm_s), .imm_u(imm_u),
    .in_valid(in_valid), .in_ready(in_ready),
    .ex_wr(ex_wr), .ex_rd(ex_rd), .ex_data(ex_data),
    .ex_is_load(ex_is_load),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_data(mem_data),
    .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .b_out(b_out),
    .illegal_sel(illegal_sel), .stall_cnt(stall_cnt)
  );

  operand_b_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .sel(sel),
    .rs2_addr(rs2_addr), .rs2_data(rs2_data),
    .imm_i(imm_i), .imm_s(imm_s), .imm_u(imm_u),
    .in_valid(in_valid), .in_ready(in_ready2),
    .ex_wr(ex_wr), .ex_rd(ex_rd), .ex_data(ex_data),
    .ex_is_load(ex_is_load),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_data(mem_data),
    .flush(flush), .out_valid(out_valid2),
    .out_ready(out_ready), .b_out(b_out2),
    .illegal_sel(illegal_sel2), .stall_cnt(stall_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic bit mdl_hazard();
    return sel == 3'd0 && ex_wr && ex_is_load
        && ex_rd == rs2_addr && rs2_addr != 5'd0;
  endfunction

  function automatic bit mdl_ready();
    bit ov;
    ov = rst_n ? m_v : 1'b0;
    return (!ov || out_ready) && !mdl_hazard() && !flush;
  endfunction

  function automatic logic [31:0] mdl_val();
    case (sel)
      3'd0: begin
        if (rs2_addr == 5'd0) return rs2_data;
        if (ex_wr && ex_rd == rs2_addr && !ex_is_load)
          return ex_data;
        if (mem_wr && mem_rd == rs2_addr) return mem_data;
        return rs2_data;
      end
      3'd1: return imm_i;
      3'd2: return imm_s;
      3'd3: return imm_u;
      default: return 32'd0;
    endcase
  endfunction

  // one clock: check comb ready, advance model, check regs
  task automatic cyc();
    bit r;
    @(negedge clk);
    r = mdl_ready();
    chk("in_ready", 64'(in_ready), 64'(r));
    chk("in_ready_w2", 64'(in_ready2), 64'(r));
    if (!rst_n) begin
      m_v = 0; m_b = '0; m_ill = 0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      if (in_valid && mdl_hazard() && !flush) begin
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
      end
      if (flush) m_v = 0;
      else if (in_valid && r) begin
        m_b = mdl_val(); m_ill = (sel > 3'd4); m_v = 1;
      end else if (out_ready) m_v = 0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_v));
    chk("b_out", 64'(b_out), 64'(m_b));
    chk("illegal_sel", 64'(illegal_sel), 64'(m_ill));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    chk("stall_cnt_w2", 64'(stall_cnt2), 64'(m_cnt2));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0]  s;
    logic [4:0]  a;
    logic [31:0] rd;
    logic        xw;
    logic [4:0]  xr;
    logic [31:0] xd;
    logic        ld;
    logic        mw;
    logic [4:0]  mr;
    logic [31:0] md;
    logic [31:0] eb;
    logic        ei;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{3'd1, 5'd0, 32'h1111_2222, 1'b0, 5'd0,
                32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                32'h0000_0010, 1'b0};
    tbl[1]  = '{3'd0, 5'd5, 32'h1111_2222, 1'b1, 5'd5,
                32'hAAAA_0001, 1'b0, 1'b1, 5'd5, 32'h5555,
                32'hAAAA_0001, 1'b0};
    tbl[2]  = '{3'd0, 5'd5, 32'h1111_2222, 1'b0, 5'd5,
                32'hAAAA_0001, 1'b0, 1'b1, 5'd5, 32'h5555,
                32'h0000_5555, 1'b0};
    tbl[3]  = '{3'd0, 5'd0, 32'h1111_2222, 1'b1, 5'd0,
                32'hAAAA_0001, 1'b0, 1'b1, 5'd0, 32'h5555,
                32'h1111_2222, 1'b0};
    tbl[4]  = '{3'd2, 5'd5, 32'h1111_2222, 1'b1, 5'd5,
                32'hAAAA_0001, 1'b0, 1'b0, 5'd0, 32'h0,
                32'hFFFF_F800, 1'b0};
    tbl[5]  = '{3'd3, 5'd1, 32'h1111_2222, 1'b0, 5'd0,
                32'h0, 1'b0, 1'b1, 5'd1, 32'h77,
                32'h1234_5000, 1'b0};
    tbl[6]  = '{3'd4, 5'd1, 32'h1111_2222, 1'b1, 5'd1,
                32'h99, 1'b0, 1'b0, 5'd0, 32'h0,
                32'h0, 1'b0};
    tbl[7]  = '{3'd5, 5'd1, 32'h1111_2222, 1'b0, 5'd0,
                32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                32'h0, 1'b1};
    tbl[8]  = '{3'd6, 5'd2, 32'h1111_2222, 1'b0, 5'd0,
                32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                32'h0, 1'b1};
    tbl[9]  = '{3'd7, 5'd3, 32'h1111_2222, 1'b0, 5'd0,
                32'h0, 1'b0, 1'b0, 5'd0, 32'h0,
                32'h0, 1'b1};
    tbl[10] = '{3'd1, 5'd4, 32'h1111_2222, 1'b1, 5'd4,
                32'hBAD0, 1'b0, 1'b1, 5'd4, 32'hBAD1,
                32'h0000_0010, 1'b0};
    tbl[11] = '{3'd0, 5'd7, 32'h1111_2222, 1'b1, 5'd3,
                32'hBAD0, 1'b0, 1'b1, 5'd7, 32'hCAFE,
                32'h0000_CAFE, 1'b0};
    tbl[12] = '{3'd0, 5'd9, 32'hDEAD_BEEF, 1'b1, 5'd8,
                32'hBAD0, 1'b0, 1'b1, 5'd10, 32'hBAD1,
                32'hDEAD_BEEF, 1'b0};

    rst_n = 0; sel = 0; rs2_addr = 0; rs2_data = 0;
    imm_i = 32'h10; imm_s = 32'hFFFF_F800;
    imm_u = 32'h1234_5000;
    in_valid = 0; ex_wr = 0; ex_rd = 0; ex_data = 0;
    ex_is_load = 0; mem_wr = 0; mem_rd = 0; mem_data = 0;
    flush = 0; out_ready = 1;
    m_v = 0; m_b = '0; m_ill = 0; m_cnt = 0; m_cnt2 = 0;

    cyc();
    cyc();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_b", 64'(b_out), 64'd0);
    chk("rst_cnt", 64'(stall_cnt), 64'd0);
    rst_n = 1;

    // decode and forwarding table
    for (int i = 0; i < 13; i++) begin
      sel = tbl[i].s; rs2_addr = tbl[i].a;
      rs2_data = tbl[i].rd; ex_wr = tbl[i].xw;
      ex_rd = tbl[i].xr; ex_data = tbl[i].xd;
      ex_is_load = tbl[i].ld; mem_wr = tbl[i].mw;
      mem_rd = tbl[i].mr; mem_data = tbl[i].md;
      in_valid = 1; out_ready = 1;
      cyc();
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("tbl%0d_b", i), 64'(b_out),
          64'(tbl[i].eb));
      chk($sformatf("tbl%0d_ill", i), 64'(illegal_sel),
          64'(tbl[i].ei));
    end

    // load-use stall for 3 cycles, then MEM forward
    do_reset();
    sel = 0; rs2_addr = 5; rs2_data = 32'h1;
    ex_wr = 1; ex_rd = 5; ex_is_load = 1; ex_data = 32'hBAD;
    mem_wr = 1; mem_rd = 5; mem_data = 32'h5555;
    in_valid = 1; out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("lu_ready", 64'(in_ready), 64'd0);
      chk("lu_valid", 64'(out_valid), 64'd0);
    end
    chk("lu_cnt", 64'(stall_cnt), 64'd3);
    ex_wr = 0;
    cyc();
    chk("lu_valid_after", 64'(out_valid), 64'd1);
    chk("lu_b_after", 64'(b_out), 64'h5555);
    chk("lu_cnt_hold", 64'(stall_cnt), 64'd3);

    // back-pressure hold for 4 cycles
    sel = 1; imm_i = 32'h10; mem_wr = 0;
    cyc();
    out_ready = 0; imm_i = 32'h20;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("bp_b", 64'(b_out), 64'h10);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1;
    cyc();
    chk("bp_release", 64'(b_out), 64'h20);
    in_valid = 0;
    cyc();
    chk("bp_drain", 64'(out_valid), 64'd0);

    // reserved select, then flush on a held valid
    sel = 6; in_valid = 1;
    cyc();
    chk("ill_b", 64'(b_out), 64'd0);
    chk("ill_flag", 64'(illegal_sel), 64'd1);
    sel = 1; out_ready = 0; flush = 1;
    cyc();
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_b_hold", 64'(b_out), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd0);
    flush = 0;

    // hazard count, narrow saturation, reset mid-stream
    do_reset();
    sel = 1; out_ready = 1; in_valid = 1;
    cyc();
    out_ready = 0; sel = 0; rs2_addr = 5;
    ex_wr = 1; ex_rd = 5; ex_is_load = 1;
    for (int k = 0; k < 7; k++) begin
      cyc();
      if (k == 4)
        chk("sat_w2", 64'(stall_cnt2), 64'd3);
    end
    chk("hz_cnt7", 64'(stall_cnt), 64'd7);
    chk("hz_valid", 64'(out_valid), 64'd1);
    rst_n = 0;
    cyc();
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_b", 64'(b_out), 64'd0);
    chk("mrst_ill", 64'(illegal_sel), 64'd0);
    chk("mrst_cnt", 64'(stall_cnt), 64'd0);
    rst_n = 1;

    // randomized traffic
    for (int k = 0; k < 500; k++) begin
      sel = ($urandom_range(0, 1) == 0) ? 3'd0
            : 3'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 3));
      rs2_data = $urandom;
      imm_i = $urandom; imm_s = $urandom; imm_u = $urandom;
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      ex_wr = 1'($urandom_range(0, 1));
      ex_rd = 5'($urandom_range(0, 3));
      ex_data = $urandom;
      ex_is_load = 1'($urandom_range(0, 1));
      mem_wr = 1'($urandom_range(0, 1));
      mem_rd = 5'($urandom_range(0, 3));
      mem_data = $urandom;
      flush = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 63) != 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
